// File: rtl/bft_config_regfile_if.sv
// bft_config_regfile_if: configuration packet, credit and readback bundle for the BFT config register file.
interface bft_config_regfile_if #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7
);
    localparam int IN_W  = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int OUT_W = IN_W + 2 * NUM_ADDR_BITS + 3;
    logic [PACKET_BITS-1:0]                           config_packet;
    logic [NUM_OUT_PORTS-1:0]                         consume;
    logic [IN_W*NUM_IN_PORTS+OUT_W*NUM_OUT_PORTS-1:0] control_reg;
    logic [NUM_ADDR_BITS*NUM_OUT_PORTS-1:0]           credit_cnt;
    logic                                             resp_valid;
    logic [PACKET_BITS-1:0]                           resp_packet;
    logic                                             resp_ready;
    logic                                             cfg_err;
    modport master (output config_packet, consume, resp_ready,
                    input  control_reg, credit_cnt, resp_valid, resp_packet, cfg_err);
    modport slave  (input  config_packet, consume, resp_ready,
                    output control_reg, credit_cnt, resp_valid, resp_packet, cfg_err);
endinterface

// File: rtl/bft_config_regfile.sv
// bft_config_regfile: BFT port routing registers, per-output credit counters and readback, fed by config packets.
module bft_config_regfile #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PAYLOAD_BITS  = 64,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int IN_PORT_BASE  = 2,
    parameter int OUT_PORT_BASE = 9,
    parameter int SHADOW_EN     = 0
) (
    input logic                 clk,
    input logic                 reset,
    bft_config_regfile_if.slave bus
);
    localparam int LB     = NUM_LEAF_BITS;
    localparam int PB     = NUM_PORT_BITS;
    localparam int AB     = NUM_ADDR_BITS;
    localparam int SW     = AB + 2;
    localparam int IN_W   = LB + PB;
    localparam int ENT_W  = IN_W + 2 * AB;
    localparam int OUT_W  = ENT_W + 3;
    localparam int CTRL_W = IN_W * NUM_IN_PORTS + OUT_W * NUM_OUT_PORTS;
    localparam logic [AB-1:0]    CMAX    = '1;
    localparam logic [IN_W-1:0]  IN_RST  = IN_W'(9);
    localparam logic [ENT_W-1:0] OUT_RST = {{LB{1'b0}}, PB'(2), {AB{1'b0}}, CMAX};
    localparam bit               SH      = SHADOW_EN != 0;

    logic [PACKET_BITS-1:0]  pkt, resp_nxt, resp_packet;
    logic [PAYLOAD_BITS-1:0] pl;
    logic [PB-1:0]           self_port, ds_port;
    logic [LB-1:0]           ds_leaf;
    logic [AB-1:0]           bram, free, amount;
    logic [31:0]             sp, pt;
    logic                    valid, cfg_in, cfg_out, rd, commit, unused_pkt;
    logic [IN_W-1:0]         new_in;
    logic [ENT_W-1:0]        new_out;
    logic [IN_W-1:0]         in_act [NUM_IN_PORTS];
    logic [IN_W-1:0]         in_sh [NUM_IN_PORTS];
    logic [ENT_W-1:0]        out_act [NUM_OUT_PORTS];
    logic [ENT_W-1:0]        out_sh [NUM_OUT_PORTS];
    logic [AB-1:0]           credit [NUM_OUT_PORTS];
    logic [AB-1:0]           credit_nxt [NUM_OUT_PORTS];
    logic [NUM_IN_PORTS-1:0] in_sel;
    logic [NUM_OUT_PORTS-1:0] out_sel, ret, load, under, upd_en, add_en;
    logic [CTRL_W-1:0]       ctrl;
    logic [OUT_W-1:0]        rd_bits;
    logic [SW-1:0]           sum;
    logic                    in_hit, out_hit, err_nxt, resp_valid, cfg_err;

    assign pkt        = bus.config_packet;
    assign unused_pkt = ^pkt;
    assign pl         = pkt[PAYLOAD_BITS-1:0];
    assign valid      = pkt[PACKET_BITS-1];
    assign pt         = 32'(pkt[PACKET_BITS-2-LB -: PB]);
    assign self_port  = pl[PAYLOAD_BITS-1 -: PB];
    assign ds_leaf    = pl[PAYLOAD_BITS-1-PB -: LB];
    assign ds_port    = pl[PAYLOAD_BITS-1-PB-LB -: PB];
    assign bram       = pl[PAYLOAD_BITS-1-2*PB-LB -: AB];
    assign free       = pl[PAYLOAD_BITS-1-2*PB-LB-AB -: AB];
    assign amount     = pl[AB-1:0];
    assign sp         = 32'(self_port);
    assign new_in     = {ds_leaf, ds_port};
    assign new_out    = {ds_leaf, ds_port, bram, free};
    assign cfg_out    = valid && pt == 0;
    assign cfg_in     = valid && pt == 1;
    assign rd         = valid && pt == 2;
    assign commit     = SH && valid && pt == 3;

    always_comb begin
        in_sel  = '0;
        out_sel = '0;
        ret     = '0;
        load    = '0;
        under   = '0;
        rd_bits = '0;
        sum     = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            in_sel[i] = sp == 32'(IN_PORT_BASE + i);
            if (in_sel[i]) rd_bits = OUT_W'(ctrl[IN_W*i +: IN_W]);
        end
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            out_sel[k] = sp == 32'(OUT_PORT_BASE + k);
            ret[k]     = valid && pt == 32'(OUT_PORT_BASE + k);
            load[k]    = SH ? commit : cfg_out && out_sel[k];
            if (out_sel[k]) rd_bits = ctrl[IN_W*NUM_IN_PORTS + OUT_W*k +: OUT_W];
            // Credit and consume net first, then clamp to the counter range
            sum           = {2'b0, credit[k]} + (ret[k] ? {2'b0, amount} : '0) - SW'(bus.consume[k]);
            credit_nxt[k] = sum[AB+1] ? '0 : sum[AB] ? CMAX : sum[AB-1:0];
            under[k]      = bus.consume[k] && credit[k] == '0 && !(ret[k] && amount != '0) && !load[k];
        end
        in_hit  = |in_sel;
        out_hit = |out_sel;
        err_nxt = (cfg_in && !in_hit) || (cfg_out && !out_hit) || |under ||
                  (rd && (!(in_hit || out_hit) || (resp_valid && !bus.resp_ready)));
        resp_nxt                            = '0;
        resp_nxt[PACKET_BITS-1]             = 1'b1;
        resp_nxt[PACKET_BITS-2 -: LB]       = ds_leaf;
        resp_nxt[PACKET_BITS-2-LB -: PB]    = ds_port;
        resp_nxt[PAYLOAD_BITS-1 -: PB]      = self_port;
        resp_nxt[OUT_W-1:0]                 = rd_bits;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                in_act[i] <= IN_RST;
                in_sh[i]  <= IN_RST;
            end
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                out_act[k] <= OUT_RST;
                out_sh[k]  <= OUT_RST;
                credit[k]  <= CMAX;
            end
            upd_en      <= '0;
            add_en      <= '0;
            resp_valid  <= 1'b0;
            resp_packet <= '0;
            cfg_err     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                if (cfg_in && in_sel[i]) in_sh[i] <= new_in;
                if (SH ? commit : cfg_in && in_sel[i]) in_act[i] <= SH ? in_sh[i] : new_in;
            end
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                if (cfg_out && out_sel[k]) out_sh[k] <= new_out;
                if (load[k]) out_act[k] <= SH ? out_sh[k] : new_out;
                credit[k] <= load[k] ? (SH ? out_sh[k][AB-1:0] : free) : credit_nxt[k];
            end
            upd_en  <= load;
            add_en  <= ret & {NUM_OUT_PORTS{pl[0]}};
            cfg_err <= err_nxt;
            if (rd && (!resp_valid || bus.resp_ready)) begin
                resp_valid  <= 1'b1;
                resp_packet <= resp_nxt;
            end else if (bus.resp_ready) resp_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        assign ctrl[IN_W*i +: IN_W] = in_act[i];
    end
    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        assign ctrl[IN_W*NUM_IN_PORTS + OUT_W*k +: OUT_W] = {upd_en[k], upd_en[k], add_en[k], out_act[k]};
        assign bus.credit_cnt[AB*k +: AB] = credit[k];
    end
    assign bus.control_reg = ctrl;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_packet = resp_packet;
    assign bus.cfg_err     = cfg_err;
endmodule

// File: tb/tb_bft_config_regfile.sv
// tb_bft_config_regfile: scenario tasks with a readback scoreboard, covering both direct and shadowed configurations.
module tb_bft_config_regfile;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [96:0]  q[$];
    logic [96:0]  e;
    logic [258:0] exp_ctrl, rst_ctrl, ec;

    bft_config_regfile_if bus0 ();
    bft_config_regfile_if bus1 ();
    bft_config_regfile #(.SHADOW_EN(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    bft_config_regfile #(.SHADOW_EN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [96:0] mk(input int p, sp, l, dp, b, f, a);
        logic [96:0] x;
        x = '0;
        x[96] = 1'b1;
        x[89:86] = 4'(p);
        x[63:60] = 4'(sp);
        x[59:54] = 6'(l);
        x[53:50] = 4'(dp);
        x[49:43] = 7'(b);
        x[42:36] = 7'(f);
        x[6:0] = 7'(a);
        return x;
    endfunction

    function automatic logic [96:0] resp(input int l, dp, sp, input logic [26:0] ent);
        logic [96:0] x;
        x = '0;
        x[96] = 1'b1;
        x[95:90] = 6'(l);
        x[89:86] = 4'(dp);
        x[63:60] = 4'(sp);
        x[26:0] = ent;
        return x;
    endfunction

    function automatic logic [26:0] oent(input logic [258:0] c, input int k);
        return c[70+27*k +: 27];
    endfunction

    function automatic logic [6:0] cred(input logic [48:0] c, input int k);
        return c[7*k +: 7];
    endfunction

    task automatic set_out(input int k, l, dp, b, f);
        exp_ctrl[70+27*k +: 27] = {3'b000, 6'(l), 4'(dp), 7'(b), 7'(f)};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 7; i++) rst_ctrl[10*i +: 10] = 10'h009;
        for (int k = 0; k < 7; k++) rst_ctrl[70+27*k +: 27] = {3'b000, 6'd0, 4'd2, 7'd0, 7'h7f};
        #1 reset = 1'b0;
        #10;
        checks++; if (bus0.control_reg !== rst_ctrl) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", bus0.control_reg, rst_ctrl); end
        checks++; if (bus0.credit_cnt !== {7{7'h7f}}) begin failures++; $display("FAIL reset_credit got=%h exp=%h", bus0.credit_cnt, {7{7'h7f}}); end
        checks++; if (bus0.resp_valid !== 1'b0 || bus0.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus0.resp_valid, bus0.cfg_err); end
        checks++; if (bus0.resp_packet !== 97'd0) begin failures++; $display("FAIL reset_resp got=%h exp=0", bus0.resp_packet); end
        checks++; if (bus1.control_reg !== rst_ctrl) begin failures++; $display("FAIL reset_ctrl_shadow got=%h exp=%h", bus1.control_reg, rst_ctrl); end
        #1 reset = 1'b1;
        tick();
        exp_ctrl = rst_ctrl;
    endtask

    task automatic test_input_write();
        bus0.config_packet = mk(1, 3, 5, 4, 0, 0, 0);
        tick();
        bus0.config_packet = '0;
        exp_ctrl[10 +: 10] = {6'd5, 4'd4};
        checks++; if (bus0.control_reg !== exp_ctrl) begin failures++; $display("FAIL input_write got=%h exp=%h", bus0.control_reg, exp_ctrl); end
        checks++; if (bus0.cfg_err !== 1'b0) begin failures++; $display("FAIL input_write_err got=%b exp=0", bus0.cfg_err); end
    endtask

    task automatic test_output_write();
        bus0.config_packet = mk(0, 9, 2, 3, 16, 40, 0);
        tick();
        bus0.config_packet = '0;
        set_out(0, 2, 3, 16, 40);
        ec = exp_ctrl;
        ec[70+26] = 1'b1;
        ec[70+25] = 1'b1;
        checks++; if (bus0.control_reg !== ec) begin failures++; $display("FAIL output_write got=%h exp=%h", bus0.control_reg, ec); end
        checks++; if (cred(bus0.credit_cnt, 0) !== 7'd40) begin failures++; $display("FAIL output_credit got=%0d exp=40", cred(bus0.credit_cnt, 0)); end
        tick();
        checks++; if (bus0.control_reg !== exp_ctrl) begin failures++; $display("FAIL update_pulse_once got=%h exp=%h", bus0.control_reg, exp_ctrl); end
    endtask

    task automatic test_credit();
        bus0.config_packet = mk(0, 9, 2, 3, 16, 126, 0);
        tick();
        bus0.config_packet = '0;
        set_out(0, 2, 3, 16, 126);
        tick();
        bus0.config_packet = mk(9, 0, 0, 0, 0, 0, 5);
        bus0.consume = 7'b0000001;
        tick();
        bus0.config_packet = '0;
        bus0.consume = '0;
        checks++; if (cred(bus0.credit_cnt, 0) !== 7'd127) begin failures++; $display("FAIL credit_saturate got=%0d exp=127", cred(bus0.credit_cnt, 0)); end
        checks++; if (oent(bus0.control_reg, 0) !== {3'b001, 24'(exp_ctrl[70 +: 24])}) begin failures++; $display("FAIL add_freespace got=%h exp=%h", oent(bus0.control_reg, 0), {3'b001, 24'(exp_ctrl[70 +: 24])}); end
        bus0.config_packet = mk(0, 9, 2, 3, 16, 0, 0);
        tick();
        bus0.config_packet = '0;
        set_out(0, 2, 3, 16, 0);
        bus0.consume = 7'b0000001;
        tick();
        bus0.consume = '0;
        checks++; if (cred(bus0.credit_cnt, 0) !== 7'd0) begin failures++; $display("FAIL consume_at_zero got=%0d exp=0", cred(bus0.credit_cnt, 0)); end
        checks++; if (bus0.cfg_err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", bus0.cfg_err); end
        bus0.consume = 7'b0000010;
        tick();
        checks++; if (bus0.cfg_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", bus0.cfg_err); end
        tick();
        tick();
        bus0.consume = '0;
        checks++; if (cred(bus0.credit_cnt, 1) !== 7'd124) begin failures++; $display("FAIL consume_dec got=%0d exp=124", cred(bus0.credit_cnt, 1)); end
        bus0.config_packet = mk(10, 0, 0, 0, 0, 0, 2);
        tick();
        bus0.config_packet = '0;
        checks++; if (cred(bus0.credit_cnt, 1) !== 7'd126) begin failures++; $display("FAIL credit_add got=%0d exp=126", cred(bus0.credit_cnt, 1)); end
        checks++; if (bus0.control_reg !== exp_ctrl) begin failures++; $display("FAIL add_freespace_even got=%h exp=%h", bus0.control_reg, exp_ctrl); end
        bus0.config_packet = mk(0, 10, 1, 1, 8, 50, 0);
        bus0.consume = 7'b0000010;
        tick();
        bus0.config_packet = '0;
        bus0.consume = '0;
        set_out(1, 1, 1, 8, 50);
        checks++; if (cred(bus0.credit_cnt, 1) !== 7'd50) begin failures++; $display("FAIL config_override got=%0d exp=50", cred(bus0.credit_cnt, 1)); end
        tick();
    endtask

    task automatic test_errors();
        bus0.config_packet = mk(1, 12, 1, 1, 0, 0, 0);
        tick();
        bus0.config_packet = '0;
        checks++; if (bus0.cfg_err !== 1'b1) begin failures++; $display("FAIL bad_input_port got=%b exp=1", bus0.cfg_err); end
        checks++; if (bus0.control_reg !== exp_ctrl) begin failures++; $display("FAIL bad_input_state got=%h exp=%h", bus0.control_reg, exp_ctrl); end
        bus0.config_packet = mk(0, 3, 1, 1, 1, 1, 0);
        tick();
        bus0.config_packet = '0;
        checks++; if (bus0.cfg_err !== 1'b1) begin failures++; $display("FAIL bad_output_port got=%b exp=1", bus0.cfg_err); end
        checks++; if (bus0.control_reg !== exp_ctrl || cred(bus0.credit_cnt, 0) !== 7'd0) begin failures++; $display("FAIL bad_output_state got=%h exp=%h", bus0.control_reg, exp_ctrl); end
        tick();
    endtask

    task automatic test_readback();
        bus0.resp_ready = 1'b0;
        bus0.config_packet = mk(2, 9, 7, 6, 0, 0, 0);
        q.push_back(resp(7, 6, 9, oent(exp_ctrl, 0)));
        tick();
        bus0.config_packet = '0;
        checks++; if (bus0.resp_valid !== 1'b1) begin failures++; $display("FAIL resp_valid_rise got=%b exp=1", bus0.resp_valid); end
        bus0.config_packet = mk(2, 3, 1, 1, 0, 0, 0);
        tick();
        bus0.config_packet = '0;
        checks++; if (bus0.cfg_err !== 1'b1) begin failures++; $display("FAIL dropped_req_err got=%b exp=1", bus0.cfg_err); end
        for (int n = 0; n < 3; n++) begin
            checks++; if (bus0.resp_valid !== 1'b1 || bus0.resp_packet !== q[0]) begin failures++; $display("FAIL resp_stable_%0d got=%b/%h exp=1/%h", n, bus0.resp_valid, bus0.resp_packet, q[0]); end
            tick();
        end
        bus0.resp_ready = 1'b1;
        e = q.pop_front();
        checks++; if (bus0.resp_packet !== e) begin failures++; $display("FAIL resp_data got=%h exp=%h", bus0.resp_packet, e); end
        tick();
        bus0.resp_ready = 1'b0;
        checks++; if (bus0.resp_valid !== 1'b0) begin failures++; $display("FAIL resp_cleared got=%b exp=0", bus0.resp_valid); end
    endtask

    task automatic test_back_to_back();
        bus0.resp_ready = 1'b1;
        bus0.config_packet = mk(2, 3, 2, 1, 0, 0, 0);
        q.push_back(resp(2, 1, 3, 27'(exp_ctrl[10 +: 10])));
        tick();
        bus0.config_packet = mk(2, 0, 3, 3, 0, 0, 0);
        q.push_back(resp(3, 3, 0, 27'd0));
        e = q.pop_front();
        checks++; if (bus0.resp_valid !== 1'b1 || bus0.resp_packet !== e) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/%h", bus0.resp_valid, bus0.resp_packet, e); end
        tick();
        bus0.config_packet = '0;
        e = q.pop_front();
        checks++; if (bus0.resp_valid !== 1'b1 || bus0.resp_packet !== e) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/%h", bus0.resp_valid, bus0.resp_packet, e); end
        checks++; if (bus0.cfg_err !== 1'b1) begin failures++; $display("FAIL rb_range_err got=%b exp=1", bus0.cfg_err); end
        tick();
        bus0.resp_ready = 1'b0;
        checks++; if (bus0.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus0.resp_valid); end
    endtask

    task automatic test_shadow();
        bus1.config_packet = mk(0, 10, 3, 1, 20, 30, 0);
        tick();
        bus1.config_packet = '0;
        checks++; if (bus1.control_reg !== rst_ctrl || cred(bus1.credit_cnt, 1) !== 7'd127) begin failures++; $display("FAIL shadow_hidden got=%h exp=%h", bus1.control_reg, rst_ctrl); end
        bus1.config_packet = mk(3, 0, 0, 0, 0, 0, 0);
        tick();
        bus1.config_packet = '0;
        ec = rst_ctrl;
        ec[70+27 +: 24] = {6'd3, 4'd1, 7'd20, 7'd30};
        for (int k = 0; k < 7; k++) ec[70+27*k+25 +: 2] = 2'b11;
        checks++; if (bus1.control_reg !== ec) begin failures++; $display("FAIL shadow_commit got=%h exp=%h", bus1.control_reg, ec); end
        checks++; if (cred(bus1.credit_cnt, 1) !== 7'd30 || cred(bus1.credit_cnt, 0) !== 7'd127) begin failures++; $display("FAIL shadow_credit got=%h", bus1.credit_cnt); end
        tick();
        for (int k = 0; k < 7; k++) ec[70+27*k+25 +: 2] = 2'b00;
        checks++; if (bus1.control_reg !== ec) begin failures++; $display("FAIL shadow_pulse_clear got=%h exp=%h", bus1.control_reg, ec); end
    endtask

    task automatic test_reset_mid();
        bus0.resp_ready = 1'b0;
        bus0.config_packet = mk(2, 9, 1, 1, 0, 0, 0);
        tick();
        bus0.config_packet = '0;
        checks++; if (bus0.resp_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", bus0.resp_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus0.resp_valid !== 1'b0 || bus0.resp_packet !== 97'd0 || bus0.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_drops_resp got=%b/%h exp=0/0", bus0.resp_valid, bus0.resp_packet); end
        checks++; if (bus0.control_reg !== rst_ctrl || bus0.credit_cnt !== {7{7'h7f}}) begin failures++; $display("FAIL reset_mid_state got=%h exp=%h", bus0.control_reg, rst_ctrl); end
        q.delete();
        bus0.config_packet = mk(1, 2, 9, 9, 0, 0, 0);
        tick();
        bus0.config_packet = '0;
        checks++; if (bus0.control_reg !== rst_ctrl) begin failures++; $display("FAIL reset_blocks_pkt got=%h exp=%h", bus0.control_reg, rst_ctrl); end
        #3 reset = 1'b1;
        tick();
    endtask

    initial begin
        bus0.config_packet = '0;
        bus0.consume = '0;
        bus0.resp_ready = 1'b0;
        bus1.config_packet = '0;
        bus1.consume = '0;
        bus1.resp_ready = 1'b0;
        test_reset();
        test_input_write();
        test_output_write();
        test_credit();
        test_errors();
        test_readback();
        test_back_to_back();
        test_shadow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bft_config_regfile.md
BFT_CONFIG_REGFILE -- requirements
Module: bft_config_regfile

Interface
REQ-001 SHALL have parameters: PACKET_BITS 97 (config/response packet width); NUM_LEAF_BITS 6; NUM_PORT_BITS 4; NUM_ADDR_BITS 7 (address/credit width); PAYLOAD_BITS 64; NUM_IN_PORTS 7; NUM_OUT_PORTS 7; IN_PORT_BASE 2 (first input self_port id); OUT_PORT_BASE 9 (first output self_port id); SHADOW_EN 0 (1 = writes staged, applied on commit).
REQ-002 SHALL have one clock, `clk  in  1`, rising-edge; all state on it.
REQ-003 SHALL have `reset  in  1`: asynchronous assert, active-low.
REQ-004 SHALL have `i_config_packet  in  PACKET_BITS`: bit MSB = valid, then leaf, then port; low PAYLOAD_BITS = payload.
REQ-005 SHALL have `i_consume  in  NUM_OUT_PORTS`: per-output one-cycle credit-consume pulse.
REQ-006 SHALL have `o_control_reg  out  IN_W*NUM_IN_PORTS + OUT_W*NUM_OUT_PORTS`: IN_W = LEAF+PORT, OUT_W = LEAF+PORT+2*ADDR+3; inputs in low bits.
REQ-007 SHALL have `o_credit_cnt  out  NUM_ADDR_BITS*NUM_OUT_PORTS`: per-output credit counters.
REQ-008 SHALL have `o_resp_valid  out  1`, `o_resp_packet  out  PACKET_BITS`, `i_resp_ready  in  1`: readback response, valid/ready.
REQ-009 SHALL have `o_cfg_err  out  1`: one-cycle error pulse.

Function
REQ-010 Payload decode: self_port = top PORT bits, then dst_src_leaf (LEAF), dst_src_port (PORT), bram_addr (ADDR), freespace (ADDR).
REQ-011 Packet ignored unless valid=1; leaf field not checked.
REQ-012 port==1, self_port in [IN_PORT_BASE, IN_PORT_BASE+NUM_IN_PORTS): input entry i <= {dst_src_leaf, dst_src_port}.
REQ-013 port==0, self_port in [OUT_PORT_BASE, OUT_PORT_BASE+NUM_OUT_PORTS): output entry k <= {dst_leaf, dst_port, bram_addr, freespace}; credit_cnt[k] <= freespace; update_freespace_en[k] and update_bram_addr_en[k] pulse high one cycle.
REQ-014 port==0 or 1 with self_port out of range: no state change; o_cfg_err pulses next cycle.
REQ-015 Per-output field order in o_control_reg, MSB first: update_freespace_en, update_bram_addr_en, add_freespace_en, dst_leaf, dst_port, bram_addr, freespace; input entry: src_leaf, src_port.
REQ-016 Configuration writes visible on o_control_reg exactly 1 cycle after the packet cycle (SHADOW_EN=0).
REQ-017 SHADOW_EN=1: REQ-012/013 writes go to shadow copies; port==3 packet copies all shadows to active registers, visible 1 cycle later; update_*_en pulse for every output at commit; credit_cnt[k] <= shadow freespace at commit. Write and commit same cycle impossible (one packet/cycle).
REQ-018 port==OUT_PORT_BASE+k: credit return; amount = payload[ADDR-1:0]; add_freespace_en[k] <= payload[0] for one cycle.
REQ-019 Credit counter next = cnt + amount - i_consume[k], saturating at 0 and 2^ADDR-1; simultaneous credit and consume net in the same cycle.
REQ-020 Config write (REQ-013/017) to k overrides any same-cycle credit/consume on k.
REQ-021 i_consume[k] at cnt==0: counter holds 0; o_cfg_err pulses.
REQ-022 port==2: readback of self_port entry; response = {1'b1, request dst_src_leaf, request dst_src_port, zero pad, payload = {self_port, active entry bits zero-extended}}.
REQ-023 Response register one deep: o_resp_valid rises 1 cycle after request; packet stable while valid && !ready; cleared when ready sampled high.
REQ-024 Readback while valid && !ready: request dropped, o_cfg_err pulses; with ready high same cycle, new request accepted, valid stays high with new contents.
REQ-025 Readback of out-of-range self_port: response returned with payload entry bits zero, plus o_cfg_err.

Reset
REQ-026 reset low asynchronously: src_leaf 0, src_port 9, dst_leaf 0, dst_port 2, bram_addr 0, freespace 2^ADDR-1 (shadows too), credit_cnt 2^ADDR-1, all enables 0, o_resp_valid 0, o_resp_packet 0, o_cfg_err 0.
REQ-027 Reset mid-handshake drops pending response; no packet processed while reset low.

Verification
REQ-028 Packet valid, port 1, self_port 3, leaf 5, port 4 -> next cycle input entry 1 = {5,4}; others unchanged.
REQ-029 Port 0, self_port 9, leaf 2, port 3, bram 16, free 40 -> entry 0 updated, credit_cnt[0]=40, both update_en pulse once.
REQ-030 credit_cnt[0]=126, credit amount 5 with i_consume[0]=1 -> 127 (saturated); cnt 0 with consume -> stays 0, o_cfg_err pulse.
REQ-031 Readback self_port 9, i_resp_ready low 3 cycles -> packet stable; second request dropped with o_cfg_err; ready high -> valid clears next cycle.
REQ-032 SHADOW_EN=1: write self_port 10 -> o_control_reg unchanged; port-3 commit -> new value visible 1 cycle later.
REQ-033 reset low mid-response -> o_resp_valid 0 immediately, all REQ-026 values.
